// File: rtl/button_event_decoder_pkg.sv
// button_event_pkg: state encoding and counter sizing shared by the button event decoder
package button_event_pkg;
  typedef enum logic [2:0] {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_HELD} btn_state_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a > b ? a : b;
    m = m > c ? m : c;
    return $clog2(m) + 1;
  endfunction
endpackage

// File: rtl/button_event_decoder_rise_detect.sv
// rise_detect: press-edge detector with previous level reset to 1
// Ports: clk, rst_n (sync, active-low), clean (debounced level), rise (clean & ~prev)
// Resetting prev to 1 makes a button already held at reset invisible until it is released.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  output logic rise
);
  logic prev_q;
  always_ff @(posedge clk) prev_q <= !rst_n ? 1'b1 : clean;
  assign rise = clean & ~prev_q;
endmodule

// File: rtl/button_event_decoder.sv
// button_event_decoder: turns a debounced button level into press/short/long/repeat events
// Ports: clk; rst_n (sync, active-low); clean (1 = pressed); enable (0 = idle, no events);
//        press_pulse, short_pulse, long_pulse, repeat_pulse (one-cycle, registered);
//        held (level, PRESSED or LONG_HELD); dbl_pulse (double click)
// Macro BTN_DOUBLE_CLICK_EN adds dbl_pulse and defers short_pulse until the re-press window closes.
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int REPEAT_CYCLES = 10_000_000,
  parameter int DBL_WINDOW    = 15_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clean,
  input  logic enable,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
`ifdef BTN_DOUBLE_CLICK_EN
  output logic dbl_pulse,
`endif
  output logic held
);
  localparam int CW = cnt_width(LONG_CYCLES, REPEAT_CYCLES, DBL_WINDOW);
  localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_MAX = CW'(REPEAT_CYCLES - 1);
`ifdef BTN_DOUBLE_CLICK_EN
  localparam logic [CW-1:0] DBL_MAX = CW'(DBL_WINDOW - 1);
  logic dbl_q, dbl_d;
`endif
  btn_state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic rise;
  logic press_q, press_d, short_q, short_d, long_q, long_d, rep_q, rep_d, held_q, held_d;
  rise_detect u_rise (
    .clk  (clk),
    .rst_n(rst_n),
    .clean(clean),
    .rise (rise)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      press_q <= 1'b0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      rep_q   <= 1'b0;
      held_q  <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
      dbl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      press_q <= press_d;
      short_q <= short_d;
      long_q  <= long_d;
      rep_q   <= rep_d;
      held_q  <= held_d;
`ifdef BTN_DOUBLE_CLICK_EN
      dbl_q   <= dbl_d;
`endif
    end
  end
  // count is cleared on every transition and whenever a state does not time anything
  always_comb begin
    state_d = state_q;
    count_d = '0;
    if (!enable) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: state_d = rise ? PRESSED : IDLE;
`ifdef BTN_DOUBLE_CLICK_EN
        PRESSED: begin
          state_d = !clean ? WAIT_SECOND : count_q == LONG_MAX ? LONG_HELD : PRESSED;
          count_d = clean && count_q != LONG_MAX ? count_q + 1'b1 : '0;
        end
        WAIT_SECOND: begin
          state_d = rise ? SECOND_HELD : count_q == DBL_MAX ? IDLE : WAIT_SECOND;
          count_d = !rise && count_q != DBL_MAX ? count_q + 1'b1 : '0;
        end
        SECOND_HELD: state_d = clean ? SECOND_HELD : IDLE;
`else
        PRESSED: begin
          state_d = !clean ? IDLE : count_q == LONG_MAX ? LONG_HELD : PRESSED;
          count_d = clean && count_q != LONG_MAX ? count_q + 1'b1 : '0;
        end
`endif
        LONG_HELD: begin
          state_d = clean ? LONG_HELD : IDLE;
          count_d = clean && count_q != REP_MAX ? count_q + 1'b1 : '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    long_d = enable && state_q == PRESSED && clean && count_q == LONG_MAX;
    rep_d  = enable && state_q == LONG_HELD && clean && count_q == REP_MAX;
    held_d = state_d == PRESSED || state_d == LONG_HELD;
`ifdef BTN_DOUBLE_CLICK_EN
    dbl_d   = enable && state_q == WAIT_SECOND && rise;
    press_d = enable && rise && (state_q == IDLE || state_q == WAIT_SECOND);
    short_d = enable && state_q == WAIT_SECOND && !rise && count_q == DBL_MAX;
`else
    press_d = enable && rise && state_q == IDLE;
    short_d = enable && state_q == PRESSED && !clean;
`endif
  end
  assign press_pulse  = press_q;
  assign short_pulse  = short_q;
  assign long_pulse   = long_q;
  assign repeat_pulse = rep_q;
  assign held         = held_q;
`ifdef BTN_DOUBLE_CLICK_EN
  assign dbl_pulse    = dbl_q;
`endif
endmodule
